cell_tt_sequencer: RTL and testbench

- Self-checking sequencer for one combinational library cell (INV, NAND, NOR, AOI, XOR class) on the characterization bench.
- Drives every input vector of the cell under test and waits a programmable settle time.
- Samples the cell output and compares it against an expected truth table.
- Reports pass/fail, mismatch count and first failing vector; sits between the bench controller and the cell under test (DUT).

---
 rtl/cell_tt_pkg.sv | 20 ++
 rtl/cell_tt_checker.sv | 64 ++++++
 rtl/cell_tt_sequencer.sv | 125 ++++++++++++
 tb/tb_cell_tt_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cell_tt_pkg.sv
// Shared types and sizing for the cell truth-table sequencer.
// Holds the FSM state encoding, vector/settle widths and the input-count clamp.
package cell_tt_pkg;

   localparam int N_IN_DEF = 4;
   localparam int TT_W_DEF = 1 << N_IN_DEF;
   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_REPORT = 2'd2
   } state_e;

   // Requested input counts above what the bench supports fall back to the maximum.
   function automatic logic [2:0] clamp_nin(input logic [2:0] nin, input logic [2:0] max_nin);
      return (nin > max_nin) ? max_nin : nin;
   endfunction

endpackage

// File: rtl/cell_tt_checker.sv
// Compares sampled cell output against the expected bit and accumulates run results.
// The mismatch counter saturates; the first failing vector is captured once per run.
module cell_tt_checker
   import cell_tt_pkg::*;
#(
   parameter int N_IN = N_IN_DEF
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clear_i,
   input  logic            sample_i,
   input  logic [N_IN-1:0] vec_i,
   input  logic            exp_i,
   input  logic            dut_y_i,
   output logic [N_IN:0]   err_cnt_o,
   output logic [N_IN-1:0] fail_vec_o,
   output logic            mm_seen_o,
   output logic            mismatch_o
);

   logic [N_IN:0]   err_cnt_q, err_cnt_d;
   logic [N_IN-1:0] fail_vec_q, fail_vec_d;
   logic            mm_seen_q, mm_seen_d;
   logic            mismatch;

   assign mismatch = sample_i && (dut_y_i != exp_i);

   always_comb begin
      err_cnt_d  = err_cnt_q;
      fail_vec_d = fail_vec_q;
      mm_seen_d  = mm_seen_q;
      if (clear_i) begin
         err_cnt_d  = '0;
         fail_vec_d = '0;
         mm_seen_d  = 1'b0;
      end else if (mismatch) begin
         if (!(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
         if (!mm_seen_q) begin
            fail_vec_d = vec_i;
         end
         mm_seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_cnt_q  <= '0;
         fail_vec_q <= '0;
         mm_seen_q  <= 1'b0;
      end else begin
         err_cnt_q  <= err_cnt_d;
         fail_vec_q <= fail_vec_d;
         mm_seen_q  <= mm_seen_d;
      end
   end

   assign err_cnt_o  = err_cnt_q;
   assign fail_vec_o = fail_vec_q;
   assign mm_seen_o  = mm_seen_q;
   assign mismatch_o = mismatch;

endmodule

// File: rtl/cell_tt_sequencer.sv
// Walks every input vector of a combinational cell, holds each for SETTLE+1 cycles,
// samples the cell output on the last held cycle and reports pass/fail via the checker.
module cell_tt_sequencer
   import cell_tt_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int SETTLE = 2
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   START,
   input  logic [2:0]             NIN,
   input  logic [(1<<N_IN)-1:0]   TT,
   output logic [N_IN-1:0]        DUT_A,
   input  logic                   DUT_Y,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   PASS,
   output logic [N_IN:0]          ERR_CNT,
   output logic [N_IN-1:0]        FAIL_VEC,
   output logic [1:0]             DBG_STATE
);

   localparam logic [2:0]          NIN_MAX    = 3'(N_IN);
   localparam logic [SETTLE_W-1:0] SETTLE_CNT = SETTLE_W'(SETTLE);

   state_e                state_q, state_d;
   logic [2:0]            nin_q, nin_d;
   logic [(1<<N_IN)-1:0]  tt_q, tt_d;
   logic [N_IN-1:0]       vec_q, vec_d;
   logic [SETTLE_W-1:0]   cnt_q, cnt_d;
   logic                  pass_q, pass_d;

   logic                  start_acc;
   logic                  sample;
   logic [N_IN-1:0]       last_vec;
   logic                  mm_seen;
   logic                  mismatch;

   assign start_acc = (state_q == ST_IDLE) && START;
   assign sample    = (state_q == ST_DRIVE) && (cnt_q == '0);
   // nin_q is already clamped, so the all-ones pattern of nin_q bits fits in N_IN.
   assign last_vec  = N_IN'((32'd1 << nin_q) - 32'd1);

   always_comb begin
      state_d = state_q;
      nin_d   = nin_q;
      tt_d    = tt_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_DRIVE;
               nin_d   = clamp_nin(NIN, NIN_MAX);
               tt_d    = TT;
               vec_d   = '0;
               cnt_d   = SETTLE_CNT;
               pass_d  = 1'b0;
            end
         end
         ST_DRIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (vec_q == last_vec) begin
               state_d = ST_REPORT;
               vec_d   = '0;
               // Fold in the final sample, which the checker registers on this same edge.
               pass_d  = ~(mm_seen | mismatch);
            end else begin
               vec_d = vec_q + 1'b1;
               cnt_d = SETTLE_CNT;
            end
         end
         ST_REPORT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         nin_q   <= '0;
         tt_q    <= '0;
         vec_q   <= '0;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nin_q   <= nin_d;
         tt_q    <= tt_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
      end
   end

   cell_tt_checker #(
      .N_IN (N_IN)
   ) u_checker (
      .clk_i      (CLK),
      .rst_i      (RST),
      .clear_i    (start_acc),
      .sample_i   (sample),
      .vec_i      (vec_q),
      .exp_i      (tt_q[vec_q]),
      .dut_y_i    (DUT_Y),
      .err_cnt_o  (ERR_CNT),
      .fail_vec_o (FAIL_VEC),
      .mm_seen_o  (mm_seen),
      .mismatch_o (mismatch)
   );

   assign DUT_A     = vec_q;
   assign BUSY      = (state_q != ST_IDLE);
   assign DONE      = (state_q == ST_REPORT);
   assign PASS      = pass_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_cell_tt_sequencer.sv
// Directed bench for cell_tt_sequencer: behavioural cell models drive DUT_Y, a scoreboard
// holds the expected DUT_A sequence and run results computed from those models.
module tb_cell_tt_sequencer;
   import cell_tt_pkg::*;

   localparam int N_IN   = 4;
   localparam int SETTLE = 2;

   logic        CLK;
   logic        RST;
   logic        START;
   logic [2:0]  NIN;
   logic [15:0] TT;
   logic [3:0]  DUT_A;
   logic        DUT_Y;
   logic        BUSY;
   logic        DONE;
   logic        PASS;
   logic [4:0]  ERR_CNT;
   logic [3:0]  FAIL_VEC;
   logic [1:0]  DBG_STATE;

   int checks = 0;
   int errors = 0;
   int model_sel = 0;

   logic [3:0] a_exp_q[$];
   logic [9:0] res_q[$];

   cell_tt_sequencer #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
      .CLK(CLK), .RST(RST), .START(START), .NIN(NIN), .TT(TT),
      .DUT_A(DUT_A), .DUT_Y(DUT_Y), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
      .ERR_CNT(ERR_CNT), .FAIL_VEC(FAIL_VEC), .DBG_STATE(DBG_STATE)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // cell models: 0 NAND2, 1 stuck-at-0, 2 INV, 3 NAND3, 4 stuck-at-1, 5 NAND4
   function automatic logic model_y(input int m, input logic [3:0] a);
      case (m)
         0:       return ~(a[0] & a[1]);
         1:       return 1'b0;
         2:       return ~a[0];
         3:       return ~(a[0] & a[1] & a[2]);
         4:       return 1'b1;
         default: return ~(&a);
      endcase
   endfunction

   assign DUT_Y = model_y(model_sel, DUT_A);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dut_a"}, 32'(DUT_A), 32'd0);
      chk({tag, "_busy"}, 32'(BUSY), 32'd0);
      chk({tag, "_done"}, 32'(DONE), 32'd0);
      chk({tag, "_pass"}, 32'(PASS), 32'd0);
      chk({tag, "_err"}, 32'(ERR_CNT), 32'd0);
      chk({tag, "_fail"}, 32'(FAIL_VEC), 32'd0);
      chk({tag, "_state"}, 32'(DBG_STATE), 32'(ST_IDLE));
   endtask

   // driver: one complete run, scoreboard filled from the model before START
   task automatic run(input logic [2:0] nin, input logic [15:0] tt, input int m,
                      input bit hold, input bit pulse, input string tag);
      int         ne;
      int         nv;
      int         nobs;
      int         err;
      int         fail;
      logic [3:0] ea;
      logic [9:0] r;
      ne   = (nin > 3'd4) ? 4 : int'(nin);
      nv   = 1 << ne;
      err  = 0;
      fail = 0;
      for (int v = 0; v < nv; v++) begin
         for (int k = 0; k <= SETTLE; k++) a_exp_q.push_back(4'(v));
         if (model_y(m, 4'(v)) != tt[v]) begin
            if (err == 0) fail = v;
            err++;
         end
      end
      res_q.push_back({(err == 0), 5'(err), 4'(fail)});
      nobs = nv * (SETTLE + 1);

      model_sel = m;
      @(negedge CLK);
      START = 1'b1;
      NIN   = nin;
      TT    = tt;
      @(posedge CLK);
      #1;
      START = hold;
      for (int i = 0; i < nobs; i++) begin
         if (i > 0) begin
            @(posedge CLK);
            #1;
         end
         ea = a_exp_q.pop_front();
         chk($sformatf("%s_a%0d", tag, i), 32'(DUT_A), 32'(ea));
         chk($sformatf("%s_busy%0d", tag, i), 32'(BUSY), 32'd1);
         chk($sformatf("%s_nodone%0d", tag, i), 32'(DONE), 32'd0);
         START = hold || (pulse && (i == 3 || i == 7));
      end
      @(posedge CLK);
      #1;
      r = res_q.pop_front();
      chk({tag, "_done"}, 32'(DONE), 32'd1);
      chk({tag, "_done_busy"}, 32'(BUSY), 32'd1);
      chk({tag, "_done_a"}, 32'(DUT_A), 32'd0);
      chk({tag, "_done_state"}, 32'(DBG_STATE), 32'(ST_REPORT));
      chk({tag, "_pass"}, 32'(PASS), 32'(r[9]));
      chk({tag, "_err"}, 32'(ERR_CNT), 32'(r[8:4]));
      chk({tag, "_fail"}, 32'(FAIL_VEC), 32'(r[3:0]));
      @(posedge CLK);
      #1;
      chk({tag, "_idle_done"}, 32'(DONE), 32'd0);
      chk({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
      chk({tag, "_hold_pass"}, 32'(PASS), 32'(r[9]));
      chk({tag, "_hold_err"}, 32'(ERR_CNT), 32'(r[8:4]));
      chk({tag, "_hold_fail"}, 32'(FAIL_VEC), 32'(r[3:0]));
   endtask

   initial begin
      RST   = 1'b1;
      START = 1'b0;
      NIN   = 3'd0;
      TT    = 16'h0000;
      #12;
      chk_reset_vals("reset");
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      chk_reset_vals("post_reset");

      run(3'd2, 16'h0007, 0, 1'b0, 1'b0, "nand2");
      run(3'd2, 16'h0006, 1, 1'b0, 1'b1, "xor_vs_zero");
      run(3'd1, 16'h0001, 2, 1'b1, 1'b0, "inv_hold");
      run(3'd1, 16'h0001, 2, 1'b0, 1'b0, "inv_b2b");

      // abort a NAND3 run with a wrong TT[0] so prior results are visibly non-zero
      model_sel = 3;
      @(negedge CLK);
      START = 1'b1;
      NIN   = 3'd3;
      TT    = 16'h007E;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      chk("abort_pre_err", 32'(ERR_CNT), 32'd1);
      chk("abort_pre_a", 32'(DUT_A), 32'd1);
      @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      chk_reset_vals("abort");
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         chk($sformatf("abort_nodone%0d", i), 32'(DONE), 32'd0);
         chk($sformatf("abort_idle%0d", i), 32'(BUSY), 32'd0);
      end

      run(3'd3, 16'h007F, 3, 1'b0, 1'b0, "nand3");
      run(3'd0, 16'h0001, 4, 1'b0, 1'b0, "tie1");
      run(3'd7, 16'h7FFF, 5, 1'b0, 1'b0, "clamp7");
      run(3'd4, 16'h8000, 5, 1'b0, 1'b0, "all_wrong");

      chk("a_queue_empty", 32'(a_exp_q.size()), 32'd0);
      chk("res_queue_empty", 32'(res_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
